// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the sequential PC step.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // normal sequential fetch
    DRAIN = 2'd1,  // stale fetch still outstanding, redirect target parked in pend_pc
    HALT  = 2'd2   // fetch stopped until reset
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage and the icache.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output imemREN, imemaddr, input ihit, imemload);
  modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch: reset > flush > write-enabled load or bubble.
module if_id_latch
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  we,
  input  logic  ld,          // with we: 1 loads the fetched word, 0 inserts a bubble
  input  word_t instr_in,
  input  word_t pcplus4_in,
  output word_t instr_out,
  output word_t pcplus4_out,
  output logic  valid_out
);

  // Latch update; a bubble clears the instruction but keeps the old PC+4.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_out   <= '0;
      pcplus4_out <= '0;
      valid_out   <= 1'b0;
    end else if (we) begin
      if (ld) begin
        instr_out   <= instr_in;
        pcplus4_out <= pcplus4_in;
        valid_out   <= 1'b1;
      end else begin
        instr_out   <= '0;
        valid_out   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, the redirect/halt FSM and the IF/ID latch.
// The request address is the PC and only moves when the cache answers, so an
// outstanding fetch never sees its address change underneath it.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  fetch_stage_if.master     imem,
  input  logic              ifW,
  input  logic              ifRST,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output word_t             instr_out,
  output word_t             pcplus4_out,
  output logic              valid_out,
  output logic              halted
);

  fetch_state_t      state, state_n;
  logic [WORD_W-1:0] pc, pc_n;
  logic [WORD_W-1:0] pend_pc, pend_n;
  logic              lat_flush, lat_we, lat_ld;
  word_t             pc_plus4;

  assign pc_plus4      = pc + PC_STEP;
  assign imem.imemaddr = pc;
  assign imem.imemREN  = !RST && (state != HALT);
  assign halted        = (state == HALT);

  // State, PC and parked redirect target.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
    end
  end

  // Next state, next PC and latch control; latch defaults to bubble-on-ifW.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_n    = pend_pc;
    lat_flush = ifRST;
    lat_we    = ifW;
    lat_ld    = 1'b0;
    unique case (state)
      FETCH: begin
        if (halt) begin
          state_n   = HALT;
          lat_flush = 1'b1;
        end else if (redirect && imem.ihit) begin
          pc_n = redirect_pc;                    // returned word is wrong-path
        end else if (redirect) begin
          pend_n  = redirect_pc;                 // wait for the stale fetch to land
          state_n = DRAIN;
        end else if (imem.ihit && ifW) begin
          pc_n   = pc_plus4;
          lat_ld = 1'b1;
        end
      end
      DRAIN: begin
        if (halt) begin
          state_n   = HALT;
          lat_flush = 1'b1;
        end else if (redirect) begin
          pend_n = redirect_pc;                  // youngest target wins
        end else if (imem.ihit) begin
          pc_n    = pend_pc;
          state_n = FETCH;
        end
      end
      HALT: begin
        lat_we = 1'b0;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  if_id_latch u_if_id (
    .clk        (CLK),
    .rst        (RST),
    .flush      (lat_flush),
    .we         (lat_we),
    .ld         (lat_ld),
    .instr_in   (imem.imemload),
    .pcplus4_in (pc_plus4),
    .instr_out  (instr_out),
    .pcplus4_out(pcplus4_out),
    .valid_out  (valid_out)
  );

endmodule
